// File: rtl/jackpot_autoplayer.sv
// jackpot_autoplayer: plays the jackpot game by watching LEDS and pressing the matching SWITCHES bit.
// Define AUTOPLAY_LFSR_EN to draw each target from an internal LFSR instead of the TARGET port.
module jackpot_autoplayer #(
  parameter int unsigned REACT_CYCLES   = 1000,
  parameter int unsigned HOLD_CYCLES    = 14000000,
  parameter int unsigned TIMEOUT_CYCLES = 56000000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic [3:0] TARGET,
  input  logic [3:0] LEDS,
  output logic [3:0] SWITCHES,
  output logic       BUSY,
  output logic       DONE,
  output logic       WIN,
  output logic       TIMEOUT
);
  typedef enum logic [2:0] {IDLE, WAIT_LED, REACT, PRESS, FINISH} state_t;
  localparam logic [31:0] REACT_LAST   = 32'(REACT_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t      state;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;
  logic [3:0]  tgt;
  logic [3:0]  pick;
  logic        seen;
  logic        match;
  logic        jackpot;
  logic        accept;
  assign cnt_inc = &cnt ? cnt : cnt + 32'd1;
  assign match   = LEDS == tgt;
  assign jackpot = LEDS == 4'hF;
`ifdef AUTOPLAY_LFSR_EN
  logic [15:0] lfsr;
  logic        unused_target;
  assign unused_target = ^TARGET;
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  assign accept = 1'b1;
  assign pick   = 4'b0001 << lfsr[1:0];
`else
  assign accept = $onehot(TARGET);
  assign pick   = TARGET;
`endif
  // one shared counter: timeout in WAIT_LED, reaction delay in REACT, hold time in PRESS
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      tgt      <= '0;
      seen     <= 1'b0;
      SWITCHES <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      WIN      <= 1'b0;
      TIMEOUT  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE:
          if (START && accept) begin
            state   <= WAIT_LED;
            tgt     <= pick;
            cnt     <= '0;
            BUSY    <= 1'b1;
            WIN     <= 1'b0;
            TIMEOUT <= 1'b0;
          end
        WAIT_LED:
          if (match) begin
            cnt <= '0;
            if (REACT_CYCLES == 0) begin
              state    <= PRESS;
              SWITCHES <= tgt;
              seen     <= 1'b0;
            end else state <= REACT;
          end else if (cnt == TIMEOUT_LAST) begin
            state   <= FINISH;
            TIMEOUT <= 1'b1;
            DONE    <= 1'b1;
          end else cnt <= cnt_inc;
        REACT:
          if (!match) begin
            state <= WAIT_LED;
            cnt   <= '0;
          end else if (cnt == REACT_LAST) begin
            state    <= PRESS;
            SWITCHES <= tgt;
            seen     <= 1'b0;
            cnt      <= '0;
          end else cnt <= cnt_inc;
        PRESS:
          if (cnt == HOLD_LAST) begin
            state    <= FINISH;
            SWITCHES <= '0;
            DONE     <= 1'b1;
            WIN      <= seen | jackpot;
            cnt      <= '0;
          end else begin
            cnt  <= cnt_inc;
            seen <= seen | jackpot;
          end
        FINISH: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_jackpot_autoplayer.sv
// tb_jackpot_autoplayer: directed scenarios checked every cycle against a match-streak model of the player.
module tb_jackpot_autoplayer;
  localparam int RC = 2;
  localparam int HC = 8;
  localparam int TC = 20;
  logic       CLOCK = 0;
  logic       RESET = 1;
  logic       START = 0;
  logic [3:0] TARGET = 0;
  logic [3:0] LEDS = 0;
  logic [3:0] SWITCHES;
  logic       BUSY, DONE, WIN, TIMEOUT;
  int passed = 0;
  int total = 0;
  int dones = 0;

  jackpot_autoplayer #(.REACT_CYCLES(RC), .HOLD_CYCLES(HC), .TIMEOUT_CYCLES(TC)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .TARGET(TARGET), .LEDS(LEDS),
    .SWITCHES(SWITCHES), .BUSY(BUSY), .DONE(DONE), .WIN(WIN), .TIMEOUT(TIMEOUT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // model: phase 0 idle, 1 hunting for a stable match, 2 holding the switch, 3 reporting
  int          ph = 0;
  int          streak = 0;
  int          waitc = 0;
  int          left = 0;
  logic [3:0]  m_tgt = 0;
  logic        m_seen = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [3:0]  e_sw = 0;
  logic        e_busy = 0, e_done = 0, e_win = 0, e_to = 0;
  logic        m_acc;
  logic [3:0]  m_pick;

  always @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      ph = 0; streak = 0; waitc = 0; left = 0; m_tgt = 0; m_seen = 0; m_lfsr = 16'hACE1;
      e_sw = 0; e_busy = 0; e_done = 0; e_win = 0; e_to = 0;
    end else begin
`ifdef AUTOPLAY_LFSR_EN
      m_acc = 1'b1;
      m_pick = 4'(1 << m_lfsr[1:0]);
`else
      m_acc = $onehot(TARGET);
      m_pick = TARGET;
`endif
      e_done = 0;
      case (ph)
        0: if (START && m_acc) begin
          ph = 1; m_tgt = m_pick; e_busy = 1; e_win = 0; e_to = 0; streak = 0; waitc = 0;
        end
        1: if (LEDS == m_tgt) begin
          streak++;
          if (streak == RC + 1) begin ph = 2; left = HC; e_sw = m_tgt; m_seen = 0; streak = 0; end
        end else if (streak > 0) begin
          streak = 0; waitc = 0;
        end else begin
          waitc++;
          if (waitc == TC) begin ph = 3; e_done = 1; e_to = 1; end
        end
        2: begin
          m_seen = m_seen | (LEDS == 4'hF);
          left--;
          if (left == 0) begin ph = 3; e_sw = 0; e_done = 1; e_win = m_seen; end
        end
        default: begin ph = 0; e_busy = 0; end
      endcase
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

  always @(negedge CLOCK) begin
    chk("cyc_switches", 32'(SWITCHES), 32'(e_sw));
    chk("cyc_busy", 32'(BUSY), 32'(e_busy));
    chk("cyc_done", 32'(DONE), 32'(e_done));
    chk("cyc_win", 32'(WIN), 32'(e_win));
    chk("cyc_timeout", 32'(TIMEOUT), 32'(e_to));
    if (DONE === 1'b1) dones++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic launch(input logic [3:0] t);
    TARGET = t; START = 1; tick(1); START = 0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (DONE !== 1'b1 && k < lim) begin tick(1); k++; end
    chk("done_within_bound", 32'(DONE), 32'd1);
  endtask

`ifdef AUTOPLAY_LFSR_EN
  logic [3:0] seq1 [8];
  logic [3:0] got;
  logic [3:0] mask = 0;

  task automatic lfsr_attempt(output logic [3:0] g);
    g = 0;
    launch(4'b0000);
    for (int i = 0; i < 16 && g == 0; i++) begin
      LEDS = 4'(1 << ((i / 3) % 4));
      tick(1);
      if (SWITCHES != 0) g = SWITCHES;
    end
    LEDS = 0;
    wait_done(20);
    tick(1);
  endtask

  initial begin
    tick(2); RESET = 0; tick(1);
    for (int a = 0; a < 64; a++) begin
      lfsr_attempt(got);
      chk("lfsr_onehot", 32'($onehot(got)), 32'd1);
      mask = mask | got;
      if (a < 8) seq1[a] = got;
    end
    chk("lfsr_all_targets", 32'(mask), 32'hF);
    RESET = 1; tick(2); RESET = 0; tick(1);
    for (int a = 0; a < 8; a++) begin
      lfsr_attempt(got);
      chk("lfsr_repeat", 32'(got), 32'(seq1[a]));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
`else
  logic [3:0] pat [3] = '{4'b0001, 4'b0010, 4'b0100};

  initial begin
    tick(2);
    chk("rst_switches", 32'(SWITCHES), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_win", 32'(WIN), 32'd0);
    chk("rst_timeout", 32'(TIMEOUT), 32'd0);
    RESET = 0; tick(1);
    launch(4'b0011); chk("illegal_two_bits", 32'(BUSY), 32'd0);
    launch(4'b0000); chk("illegal_zero", 32'(BUSY), 32'd0);
    chk("illegal_no_done", 32'(dones), 32'd0);
    launch(4'b0010); chk("win_busy", 32'(BUSY), 32'd1);
    LEDS = 4'b0010; tick(2);
    chk("win_before_react", 32'(SWITCHES), 32'd0);
    tick(1); chk("win_press_start", 32'(SWITCHES), 32'b0010);
    LEDS = 4'hF; tick(7);
    chk("win_press_last", 32'(SWITCHES), 32'b0010);
    tick(1);
    chk("win_done", 32'(DONE), 32'd1);
    chk("win_win", 32'(WIN), 32'd1);
    chk("win_timeout", 32'(TIMEOUT), 32'd0);
    chk("win_release", 32'(SWITCHES), 32'd0);
    tick(1);
    chk("win_done_pulse", 32'(DONE), 32'd0);
    chk("win_idle", 32'(BUSY), 32'd0);
    chk("win_sticky", 32'(WIN), 32'd1);
    LEDS = 0; dones = 0;
    launch(4'b0100);
    chk("start_clears_win", 32'(WIN), 32'd0);
    LEDS = 4'b0100; tick(1); LEDS = 0; tick(4);
    chk("miss_no_press", 32'(SWITCHES), 32'd0);
    chk("miss_still_busy", 32'(BUSY), 32'd1);
    LEDS = 4'b0100; tick(3);
    chk("miss_then_press", 32'(SWITCHES), 32'b0100);
    TARGET = 4'b0001; START = 1; tick(1); START = 0;
    chk("busy_start_ignored", 32'(SWITCHES), 32'b0100);
    wait_done(20);
    chk("miss_win", 32'(WIN), 32'd0);
    chk("miss_timeout", 32'(TIMEOUT), 32'd0);
    tick(1); chk("one_done_only", 32'(dones), 32'd1);
    LEDS = 0;
    launch(4'b1000);
    for (int i = 0; i < 19; i++) begin LEDS = pat[i % 3]; tick(1); end
    chk("to_not_yet", 32'(DONE), 32'd0);
    LEDS = pat[0]; tick(1);
    chk("to_done", 32'(DONE), 32'd1);
    chk("to_timeout", 32'(TIMEOUT), 32'd1);
    chk("to_win", 32'(WIN), 32'd0);
    chk("to_switches", 32'(SWITCHES), 32'd0);
    tick(1); chk("to_sticky", 32'(TIMEOUT), 32'd1);
    LEDS = 0;
    launch(4'b0001);
    chk("start_clears_timeout", 32'(TIMEOUT), 32'd0);
    LEDS = 4'b0001; tick(4);
    chk("rp_pressed", 32'(SWITCHES), 32'b0001);
    LEDS = 4'hF; tick(2);
    #2 RESET = 1;
    #1;
    chk("rp_switches", 32'(SWITCHES), 32'd0);
    chk("rp_busy", 32'(BUSY), 32'd0);
    chk("rp_win", 32'(WIN), 32'd0);
    tick(1); RESET = 0; LEDS = 0; tick(1);
    launch(4'b0010);
    chk("rp_restart_busy", 32'(BUSY), 32'd1);
    LEDS = 4'b0010; tick(3);
    chk("rp_restart_press", 32'(SWITCHES), 32'b0010);
    wait_done(20);
    chk("rp_restart_win", 32'(WIN), 32'd0);
    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
`endif
endmodule
